// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit pipelined processor: opcodes, instruction
// field positions and per-opcode operand usage helpers.
package cpu_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_LW  = 4'h5;
    localparam logic [3:0] OP_SW  = 4'h6;
    localparam logic [3:0] OP_LI  = 4'h7;
    localparam logic [3:0] OP_JR  = 4'h8;
    localparam logic [3:0] OP_BEZ = 4'h9;

    localparam int OP_HI = 7;
    localparam int OP_LO = 4;
    localparam int RA_HI = 3;
    localparam int RA_LO = 2;
    localparam int RB_HI = 1;
    localparam int RB_LO = 0;

    localparam logic [7:0] NOP_INST = 8'h00;

    function automatic logic is_illegal(input logic [3:0] op);
        return op > OP_BEZ;
    endfunction

    function automatic logic uses_ra(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SW, OP_BEZ: return 1'b1;
            default:                                      return 1'b0;
        endcase
    endfunction

    function automatic logic uses_rb(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_LW, OP_SW,
            OP_JR, OP_BEZ:                                return 1'b1;
            default:                                      return 1'b0;
        endcase
    endfunction

    function automatic logic writes_ra(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_LW, OP_LI:  return 1'b1;
            default:                                      return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/regfile4x8.sv
// 4x8 register file: two asynchronous read ports with write-first bypass,
// one synchronous write port, synchronous reset to zero.
module regfile4x8 (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] ra_addr,
    input  logic [1:0] rb_addr,
    output logic [7:0] ra_data,
    output logic [7:0] rb_data,
    input  logic       we,
    input  logic [1:0] waddr,
    input  logic [7:0] wdata
);

    logic [7:0] regs_q [4];
    logic [7:0] regs_d [4];

    always_comb begin
        regs_d = regs_q;
        if (we) regs_d[waddr] = wdata;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) regs_q[i] <= 8'h00;
        end else begin
            regs_q <= regs_d;
        end
    end

    // A same-cycle write is visible to readers so decode never sees stale data.
    always_comb begin
        ra_data = (we && waddr == ra_addr) ? wdata : regs_q[ra_addr];
        rb_data = (we && waddr == rb_addr) ? wdata : regs_q[rb_addr];
    end

endmodule

// File: rtl/id_stage.sv
// Decode stage: IF/ID register, register file, write scoreboard, hazard
// detection, jump/branch resolution and the registered ID/EX interface.
module id_stage
    import cpu_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] inst,
    input  logic [7:0] pc_calc,
    input  logic       wb_en,
    input  logic [1:0] wb_addr,
    input  logic [7:0] wb_data,
    output logic [7:0] pcj_mux,
    output logic       choice_mux,
    output logic       stall,
    output logic       ex_valid,
    output logic [3:0] ex_op,
    output logic [1:0] ex_dst,
    output logic       ex_we,
    output logic [7:0] ex_a,
    output logic [7:0] ex_b,
    output logic       illegal
);

    logic [7:0] ifid_q, ifid_d;
    logic [7:0] ifid_pc_q, ifid_pc_d;
    logic [3:0] busy_q, busy_d;
    logic       illegal_q, illegal_d;
    logic       ex_valid_q, ex_valid_d;
    logic [3:0] ex_op_q, ex_op_d;
    logic [1:0] ex_dst_q, ex_dst_d;
    logic       ex_we_q, ex_we_d;
    logic [7:0] ex_a_q, ex_a_d;
    logic [7:0] ex_b_q, ex_b_d;

    logic [3:0] raw_op, dec_op;
    logic [1:0] ra_idx, rb_idx;
    logic [7:0] ra_data, rb_data;
    logic       illegal_op, taken;
    logic [3:0] wb_clr, busy_eff;
    logic       dbg_pc_unused;

    assign raw_op = ifid_q[OP_HI:OP_LO];
    assign ra_idx = ifid_q[RA_HI:RA_LO];
    assign rb_idx = ifid_q[RB_HI:RB_LO];

    // The fetch PC is only kept alongside the instruction for debug visibility.
    assign dbg_pc_unused = ^ifid_pc_q;

    regfile4x8 u_regfile (
        .clock   (clock),
        .reset   (reset),
        .ra_addr (ra_idx),
        .rb_addr (rb_idx),
        .ra_data (ra_data),
        .rb_data (rb_data),
        .we      (wb_en),
        .waddr   (wb_addr),
        .wdata   (wb_data)
    );

    // A write-back this cycle releases its busy bit before hazard evaluation.
    always_comb begin
        illegal_op = is_illegal(raw_op);
        dec_op     = illegal_op ? OP_NOP : raw_op;
        wb_clr     = wb_en ? (4'b0001 << wb_addr) : 4'b0000;
        busy_eff   = busy_q & ~wb_clr;
        stall      = (uses_ra(dec_op) && busy_eff[ra_idx]) ||
                     (uses_rb(dec_op) && busy_eff[rb_idx]);
        pcj_mux    = (dec_op == OP_JR || dec_op == OP_BEZ) ? rb_data : 8'h00;
        taken      = !stall && (dec_op == OP_JR ||
                                (dec_op == OP_BEZ && ra_data == 8'h00));
        choice_mux = taken;
    end

    always_comb begin
        ifid_d     = inst;
        ifid_pc_d  = pc_calc;
        busy_d     = busy_eff;
        illegal_d  = illegal_q | (illegal_op && !stall);
        ex_valid_d = 1'b0;
        ex_op_d    = 4'h0;
        ex_dst_d   = 2'd0;
        ex_we_d    = 1'b0;
        ex_a_d     = 8'h00;
        ex_b_d     = 8'h00;
        if (stall) begin
            ifid_d    = ifid_q;
            ifid_pc_d = ifid_pc_q;
        end else begin
            if (taken) ifid_d = NOP_INST;
            if (dec_op != OP_NOP) begin
                ex_valid_d = 1'b1;
                ex_op_d    = dec_op;
                ex_dst_d   = ra_idx;
                ex_we_d    = writes_ra(dec_op);
                ex_a_d     = ra_data;
                ex_b_d     = (dec_op == OP_LI) ? {6'b0, rb_idx} : rb_data;
                if (writes_ra(dec_op)) busy_d = busy_eff | (4'b0001 << ra_idx);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ifid_q     <= NOP_INST;
            ifid_pc_q  <= 8'h00;
            busy_q     <= 4'b0000;
            illegal_q  <= 1'b0;
            ex_valid_q <= 1'b0;
            ex_op_q    <= 4'h0;
            ex_dst_q   <= 2'd0;
            ex_we_q    <= 1'b0;
            ex_a_q     <= 8'h00;
            ex_b_q     <= 8'h00;
        end else begin
            ifid_q     <= ifid_d;
            ifid_pc_q  <= ifid_pc_d;
            busy_q     <= busy_d;
            illegal_q  <= illegal_d;
            ex_valid_q <= ex_valid_d;
            ex_op_q    <= ex_op_d;
            ex_dst_q   <= ex_dst_d;
            ex_we_q    <= ex_we_d;
            ex_a_q     <= ex_a_d;
            ex_b_q     <= ex_b_d;
        end
    end

    assign ex_valid = ex_valid_q;
    assign ex_op    = ex_op_q;
    assign ex_dst   = ex_dst_q;
    assign ex_we    = ex_we_q;
    assign ex_a     = ex_a_q;
    assign ex_b     = ex_b_q;
    assign illegal  = illegal_q;

endmodule

// File: tb/tb_id_stage.sv
// Directed and randomized bench for id_stage against an instruction-level
// reference model of decode, scoreboard and branch resolution.
module tb_id_stage;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] inst = 8'h00;
    logic [7:0] pc_calc = 8'h00;
    logic       wb_en = 1'b0;
    logic [1:0] wb_addr = 2'd0;
    logic [7:0] wb_data = 8'h00;
    logic [7:0] pcj_mux;
    logic       choice_mux;
    logic       stall;
    logic       ex_valid;
    logic [3:0] ex_op;
    logic [1:0] ex_dst;
    logic       ex_we;
    logic [7:0] ex_a;
    logic [7:0] ex_b;
    logic       illegal;

    int tests = 0;
    int failures = 0;

    logic [7:0] m_regs [4];
    logic [3:0] m_busy = 4'b0000;
    logic [7:0] m_ifid = 8'h00;
    logic       m_illegal = 1'b0;
    logic       m_known = 1'b0;
    logic       e_valid = 1'b0;
    logic [3:0] e_op = 4'h0;
    logic [1:0] e_dst = 2'd0;
    logic       e_we = 1'b0;
    logic [7:0] e_a = 8'h00;
    logic [7:0] e_b = 8'h00;

    logic       obs_stall, obs_choice;
    logic [7:0] obs_pcj;

    id_stage dut (
        .clock      (clock),
        .reset      (reset),
        .inst       (inst),
        .pc_calc    (pc_calc),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .pcj_mux    (pcj_mux),
        .choice_mux (choice_mux),
        .stall      (stall),
        .ex_valid   (ex_valid),
        .ex_op      (ex_op),
        .ex_dst     (ex_dst),
        .ex_we      (ex_we),
        .ex_a       (ex_a),
        .ex_b       (ex_b),
        .illegal    (illegal)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic [7:0] modelRead(input logic [1:0] idx);
        return (wb_en && wb_addr == idx) ? wb_data : m_regs[idx];
    endfunction

    // One clock cycle: drive inputs, check decode-side outputs, clock, then
    // check the ID/EX outputs against the reference model.
    task automatic applyStimulus(input logic rst, input logic [7:0] ins,
                                 input logic we, input logic [1:0] wa,
                                 input logic [7:0] wd);
        logic [3:0] op;
        logic [1:0] ra, rb;
        logic       rda, rdb, wra, illeg, x_stall, x_taken;
        logic [7:0] va, vb, x_pcj;
        @(negedge clock);
        reset   = rst;
        inst    = ins;
        pc_calc = 8'($urandom);
        wb_en   = we;
        wb_addr = wa;
        wb_data = wd;
        #1;
        op    = m_ifid[7:4];
        ra    = m_ifid[3:2];
        rb    = m_ifid[1:0];
        illeg = op > 4'd9;
        if (illeg) op = 4'd0;
        rda     = op inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd9};
        rdb     = op inside {[4'd1:4'd6], 4'd8, 4'd9};
        wra     = op inside {[4'd1:4'd5], 4'd7};
        x_stall = (rda && m_busy[ra] && !(we && wa == ra)) ||
                  (rdb && m_busy[rb] && !(we && wa == rb));
        va      = modelRead(ra);
        vb      = modelRead(rb);
        x_taken = !x_stall && (op == 4'd8 || (op == 4'd9 && va == 8'h00));
        x_pcj   = (op == 4'd8 || op == 4'd9) ? vb : 8'h00;
        obs_stall  = stall;
        obs_choice = choice_mux;
        obs_pcj    = pcj_mux;
        if (m_known) begin
            checkOutput("stall", {7'b0, stall}, {7'b0, x_stall});
            checkOutput("choice_mux", {7'b0, choice_mux}, {7'b0, x_taken});
            checkOutput("pcj_mux", pcj_mux, x_pcj);
        end
        @(posedge clock);
        e_valid = 1'b0; e_op = 4'h0; e_dst = 2'd0; e_we = 1'b0; e_a = 8'h00; e_b = 8'h00;
        if (rst) begin
            for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
            m_busy    = 4'b0000;
            m_ifid    = 8'h00;
            m_illegal = 1'b0;
        end else begin
            if (we) begin
                m_regs[wa] = wd;
                m_busy[wa] = 1'b0;
            end
            if (!x_stall) begin
                if (op != 4'd0) begin
                    e_valid = 1'b1;
                    e_op    = op;
                    e_dst   = ra;
                    e_we    = wra;
                    e_a     = va;
                    e_b     = (op == 4'd7) ? {6'b0, rb} : vb;
                    if (wra) m_busy[ra] = 1'b1;
                end
                m_illegal = m_illegal | illeg;
                m_ifid    = x_taken ? 8'h00 : ins;
            end
        end
        m_known = 1'b1;
        #1;
        checkOutput("ex_valid", {7'b0, ex_valid}, {7'b0, e_valid});
        checkOutput("ex_op", {4'b0, ex_op}, {4'b0, e_op});
        checkOutput("ex_dst", {6'b0, ex_dst}, {6'b0, e_dst});
        checkOutput("ex_we", {7'b0, ex_we}, {7'b0, e_we});
        checkOutput("ex_a", ex_a, e_a);
        checkOutput("ex_b", ex_b, e_b);
        checkOutput("illegal", {7'b0, illegal}, {7'b0, m_illegal});
    endtask

    initial begin
        for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;

        // Reset held for two cycles.
        applyStimulus(1'b1, 8'h00, 1'b0, 2'd0, 8'h00);
        applyStimulus(1'b1, 8'h00, 1'b0, 2'd0, 8'h00);
        checkOutput("rst_ex_valid", {7'b0, ex_valid}, 8'h00);
        checkOutput("rst_illegal", {7'b0, illegal}, 8'h00);

        // LI r1,3 issues, then ADD r2,r1 waits on the scoreboard.
        applyStimulus(1'b0, 8'h77, 1'b0, 2'd0, 8'h00);
        applyStimulus(1'b0, 8'h19, 1'b0, 2'd0, 8'h00);
        checkOutput("li_valid", {7'b0, ex_valid}, 8'h01);
        checkOutput("li_op", {4'b0, ex_op}, 8'h07);
        checkOutput("li_dst", {6'b0, ex_dst}, 8'h01);
        checkOutput("li_b", ex_b, 8'h03);
        checkOutput("li_we", {7'b0, ex_we}, 8'h01);
        applyStimulus(1'b0, 8'h00, 1'b0, 2'd0, 8'h00);
        checkOutput("haz_stall", {7'b0, obs_stall}, 8'h01);
        checkOutput("haz_bubble", {7'b0, ex_valid}, 8'h00);
        applyStimulus(1'b0, 8'h00, 1'b1, 2'd1, 8'h03);
        checkOutput("haz_release", {7'b0, obs_stall}, 8'h00);
        checkOutput("add_op", {4'b0, ex_op}, 8'h01);
        checkOutput("add_b", ex_b, 8'h03);

        // Preload R2=0x40, R3=0x20 and take JR r2.
        applyStimulus(1'b0, 8'h00, 1'b1, 2'd2, 8'h40);
        applyStimulus(1'b0, 8'h82, 1'b1, 2'd3, 8'h20);
        applyStimulus(1'b0, 8'h77, 1'b0, 2'd0, 8'h00);
        checkOutput("jr_choice", {7'b0, obs_choice}, 8'h01);
        checkOutput("jr_target", obs_pcj, 8'h40);
        checkOutput("jr_we", {7'b0, ex_we}, 8'h00);
        applyStimulus(1'b0, 8'h93, 1'b0, 2'd0, 8'h00);
        checkOutput("jr_flush", {7'b0, ex_valid}, 8'h00);

        // BEZ r0,r3 taken with R0=0, then not taken with R0=5.
        applyStimulus(1'b0, 8'h77, 1'b0, 2'd0, 8'h00);
        checkOutput("bez_taken", {7'b0, obs_choice}, 8'h01);
        checkOutput("bez_target", obs_pcj, 8'h20);
        applyStimulus(1'b0, 8'h93, 1'b1, 2'd0, 8'h05);
        applyStimulus(1'b0, 8'h77, 1'b0, 2'd0, 8'h00);
        checkOutput("bez_not_taken", {7'b0, obs_choice}, 8'h00);
        applyStimulus(1'b0, 8'h70, 1'b0, 2'd0, 8'h00);
        checkOutput("bez_next_op", {4'b0, ex_op}, 8'h07);
        checkOutput("bez_next_valid", {7'b0, ex_valid}, 8'h01);

        // BEZ with ra busy after LI r0,0 resolves through the bypass.
        applyStimulus(1'b0, 8'h93, 1'b0, 2'd0, 8'h00);
        applyStimulus(1'b0, 8'h00, 1'b0, 2'd0, 8'h00);
        checkOutput("bbusy_stall", {7'b0, obs_stall}, 8'h01);
        checkOutput("bbusy_choice", {7'b0, obs_choice}, 8'h00);
        applyStimulus(1'b0, 8'h00, 1'b0, 2'd0, 8'h00);
        checkOutput("bbusy_stall2", {7'b0, obs_stall}, 8'h01);
        applyStimulus(1'b0, 8'h77, 1'b1, 2'd0, 8'h00);
        checkOutput("bbusy_release", {7'b0, obs_stall}, 8'h00);
        checkOutput("bbusy_taken", {7'b0, obs_choice}, 8'h01);
        checkOutput("bbusy_target", obs_pcj, 8'h20);

        // Illegal opcode is sticky; reset during a stall clears everything.
        applyStimulus(1'b0, 8'hF0, 1'b0, 2'd0, 8'h00);
        applyStimulus(1'b0, 8'h00, 1'b0, 2'd0, 8'h00);
        checkOutput("illegal_set", {7'b0, illegal}, 8'h01);
        applyStimulus(1'b0, 8'h00, 1'b0, 2'd0, 8'h00);
        applyStimulus(1'b0, 8'h19, 1'b0, 2'd0, 8'h00);
        checkOutput("illegal_sticky", {7'b0, illegal}, 8'h01);
        applyStimulus(1'b0, 8'h00, 1'b0, 2'd0, 8'h00);
        checkOutput("pre_rst_stall", {7'b0, obs_stall}, 8'h01);
        applyStimulus(1'b1, 8'h00, 1'b0, 2'd0, 8'h00);
        checkOutput("rst_clr_illegal", {7'b0, illegal}, 8'h00);
        applyStimulus(1'b0, 8'h19, 1'b0, 2'd0, 8'h00);
        checkOutput("post_rst_stall", {7'b0, obs_stall}, 8'h00);
        applyStimulus(1'b0, 8'h00, 1'b0, 2'd0, 8'h00);
        checkOutput("sb_cleared", {7'b0, obs_stall}, 8'h00);

        // Random instruction and write-back traffic with occasional resets.
        for (int n = 0; n < 400; n++) begin
            applyStimulus(($urandom_range(0, 49) == 0), 8'($urandom),
                          ($urandom_range(0, 1) == 1), 2'($urandom),
                          8'($urandom_range(0, 3) == 0 ? 0 : $urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/id_stage.md
# id_stage

Instruction decode stage of the 8-bit pipelined processor, sitting directly downstream of the fetch stage and consuming its `inst`/`pc_calc` outputs. It holds the IF/ID pipeline register, the 4×8 register file and a write scoreboard. It resolves jumps and branches, driving `pcj_mux`/`choice_mux` back to fetch, and raises `stall` on operand hazards. Decoded operations are issued to EX through a registered ID/EX interface.

## Interface
- `NOP_INST`, 8'h00: instruction injected on reset, flush and bubble.
- `clock` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `inst` input 8: instruction fetched this cycle.
- `pc_calc` input 8: fetch PC+1; sampled with `inst`; unused by decode, carried for debug.
- `wb_en` input 1: register write-back strobe.
- `wb_addr` input 2: write-back register index.
- `wb_data` input 8: write-back data.
- `pcj_mux` output 8: jump target to fetch.
- `choice_mux` output 1: 1 selects `pcj_mux` as the next PC.
- `stall` output 1: fetch holds its PC.
- `ex_valid` output 1: ID/EX holds a real instruction.
- `ex_op` output 4: opcode.
- `ex_dst` output 2: destination index.
- `ex_we` output 1: instruction writes `ex_dst`.
- `ex_a` output 8: operand A.
- `ex_b` output 8: operand B.
- `illegal` output 1: sticky; set by an illegal opcode in ID.

## Operation
- Format: opcode `[7:4]`, `ra` `[3:2]`, `rb` `[1:0]`.
- 0 NOP; 1 ADD, 2 SUB, 3 AND, 4 OR: `ra ← ra op rb`.
- 5 LW: `ra ← mem[R[rb]]`. 6 SW: `mem[R[rb]] ← R[ra]`, no register write.
- 7 LI: `ra ← {6'b0, rb}`; `ex_b` carries the immediate.
- 8 JR: PC ← R[rb].
- 9 BEZ: if R[ra]==0 then PC ← R[rb].
- A–F illegal: decoded as NOP and set `illegal`.
- Sources: ALU ops and SW read ra and rb. LW and JR read rb. BEZ reads ra and rb. LI and NOP read nothing.
- Register file: 4×8, write-first. When `wb_en` and `wb_addr` equal a source index, the read returns `wb_data`.
- Scoreboard: 4 busy bits.
  - A bit is set when an instruction with `ex_we`=1 issues with that `ex_dst`.
  - A bit is cleared by `wb_en` at `wb_addr`.
  - Set and clear of the same bit in the same cycle: set wins.
- Hazard: `stall`=1 when any source of the IF/ID instruction is busy and is not being cleared by `wb_en` this cycle. Destination busy alone does not stall; the pipeline is in order with fixed latency.
- Stall effects:
  - IF/ID holds its contents.
  - ID/EX loads a bubble (`ex_valid`=0, `ex_we`=0).
  - `choice_mux` is forced to 0.
  - The scoreboard is not set.
- Taken jump: JR, or BEZ with the zero condition met, when not stalled.
  - `choice_mux`=1 and `pcj_mux`=target.
  - At that edge IF/ID loads `NOP_INST` instead of `inst`, flushing the wrong-path fetch.
  - The jump itself issues to EX with `ex_we`=0.
- Not-taken BEZ: `choice_mux`=0, no flush.
- `pcj_mux` = R[rb] after bypass whenever the IF/ID instruction is JR or BEZ; otherwise 0.
- `illegal` is set on the edge at which an illegal opcode leaves ID unstalled. Only `reset` clears it.

## Timing
- `stall`, `choice_mux` and `pcj_mux` are combinational from IF/ID contents, the register file, the scoreboard and `wb_*`. Fetch acts on them at the same edge.
- Latency: `inst` sampled at edge N appears decoded on `ex_*` after edge N+1, absent stalls.
- Jump penalty: 1 cycle (one flushed slot).
- Reset, effective at the edge while `reset`=1:
  - IF/ID is loaded with `NOP_INST`.
  - All registers are cleared to 0.
  - The scoreboard is cleared.
  - `ex_*` are cleared to 0 and `illegal` is cleared to 0.
- Combinational outputs during reset: the IF/ID NOP gives `stall`=0, `choice_mux`=0, `pcj_mux`=0.
- Reset mid-stall or mid-flush discards the pending instruction.
- `wb_en` is honoured during the same cycle as any stall.
- Write-back of an index not marked busy still writes the register file.

## Structure
- Shared package `cpu_pkg`:
  - opcode constants `OP_NOP` … `OP_BEZ`
  - field slice localparams
  - `NOP_INST`
  - helper functions `uses_ra`, `uses_rb`, `writes_ra`
- One sub-module `regfile4x8`: two async read ports with write-first bypass, one sync write port, sync reset.
- Scoreboard, hazard logic, jump resolution and pipeline registers stay in `id_stage`.

## Test plan
- **Reset and basic issue:** hold reset 2 cycles, then release.
  - During reset: every output is 0.
  - Feed `LI r1,3` (8'h77): one edge after IF/ID capture, `ex_valid`=1, `ex_op`=7, `ex_dst`=1, `ex_b`=3, `ex_we`=1; busy[1] set.
- **Register hazard:** `LI r1,3` then `ADD r2,r1` (8'h19) with no write-back.
  - `stall`=1 and bubbles issue while busy[1] is set.
  - Pulse `wb_en`, `wb_addr`=1, `wb_data`=3: in that same cycle `stall`=0 and ADD issues with `ex_b`=3.
- **Taken JR:** preload R2=8'h40, then feed JR r2 (8'h82).
  - `choice_mux`=1, `pcj_mux`=8'h40.
  - The following fetched instruction is replaced: next `ex_valid`=0 after the JR issue.
- **BEZ both ways:** BEZ r0,r3 (8'h93) with R3=8'h20.
  - R0=0: taken with `pcj_mux`=8'h20.
  - R0=5: `choice_mux`=0 and the next instruction issues normally.
- **Branch on busy register:** BEZ with its ra busy.
  - `choice_mux` stays 0 and `stall`=1 until write-back.
  - The branch then resolves in the write-back cycle via bypass.
- **Illegal and reset mid-stall:** feed 8'hF0, then apply reset during a stall.
  - 8'hF0: `illegal`=1 and stays 1 across following NOPs.
  - Reset during the stall: `illegal`=0, the scoreboard is cleared and `stall`=0 after the reset edge.
